// File: rtl/instr_prefetch_queue_pkg.sv
// pipeline_pkg: shared fetch-side constants and the queue entry type
package pipeline_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: redirect, imem request/response and IF/ID handshake bundle
// master: the prefetch queue; slave: memory, branch resolution and IF/ID side.
interface instr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic imem_req_valid;
  logic [31:0] imem_req_addr;
  logic imem_req_ready;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic if_ready;
  logic [CW-1:0] outstanding;
  modport master (
    input redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc4, outstanding
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc4, outstanding
  );
endinterface

// File: rtl/instr_prefetch_queue_sync_fifo_2w.sv
// sync_fifo_2w: generic synchronous FIFO with push/pop/flush and occupancy count
// Ports: clk, reset (sync, active-low), push/din, pop/dout (head, valid while !empty),
// flush (empties the FIFO, overrides push/pop), count, full, empty. DEPTH must be a power of 2.
module sync_fifo_2w #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (reset && !flush && do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher with in-order word queue toward IF/ID
// Ports: clk, reset (sync, active-low); bus (master) carries redirect_valid/redirect_pc,
// imem_req_valid/addr/ready, imem_rsp_valid/data, if_valid/if_instr/if_pc4/if_ready, outstanding.
module instr_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  instr_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc, rsp_pc;
  logic [CW-1:0] out_cnt, drop_cnt, count;
  logic [CW:0] live;
  logic accept, keep, full, empty;
  logic [2*INSTR_W-1:0] head_raw;
  fetch_entry_t head;
  // live = queued words plus in-flight words that will be kept; each holds a reserved slot
  assign live = {1'b0, count} + {1'b0, out_cnt} - {1'b0, drop_cnt};
  // out_cnt bound stops stale in-flight words from letting outstanding exceed DEPTH
  assign bus.imem_req_valid = reset && !bus.redirect_valid && live < (CW+1)'(DEPTH) && out_cnt < CW'(DEPTH);
  assign bus.imem_req_addr = fetch_pc;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign keep = bus.imem_rsp_valid && drop_cnt == '0 && !bus.redirect_valid;
  sync_fifo_2w #(.WIDTH(2*INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(keep),
    .pop(!empty && bus.if_ready),
    .flush(bus.redirect_valid),
    .din({bus.imem_rsp_data, rsp_pc + PC_STEP}),
    .dout(head_raw),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign head = fetch_entry_t'(head_raw);
  assign bus.if_valid = !empty;
  assign bus.if_instr = empty ? NOP_INSTR : head.instr;
  assign bus.if_pc4 = empty ? 32'h0 : head.pc4;
  assign bus.outstanding = out_cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= word_align(RESET_PC);
      rsp_pc <= word_align(RESET_PC);
      out_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(accept) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        fetch_pc <= word_align(bus.redirect_pc);
        rsp_pc <= word_align(bus.redirect_pc);
        // a response landing in the redirect cycle is already discarded, so it is not counted
        drop_cnt <= out_cnt - CW'(bus.imem_rsp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (keep) rsp_pc <= rsp_pc + PC_STEP;
        if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end
  q_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(keep && full));
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: randomized and directed check of instr_prefetch_queue against a queue-level model
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int ep;
    int due;
  } pend_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;
  logic clk = 0;
  logic rst_n;
  instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();
  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  pend_t pend[$];
  ent_t mq[$];
  logic [31:0] fpc;
  int epoch = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1;
  bit chk_en = 0;
  logic s_if_valid, s_req_valid;
  logic [31:0] s_if_instr, s_if_pc4, s_req_addr, s_out;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h at cycle %0d", n, a, e, cyc);
    end
  endtask
  // one clock cycle: drive inputs, compare outputs against the model, then advance the model
  task automatic step(input bit rn, input bit rd, input logic [31:0] rpc, input bit rdy, input bit ifr);
    bit rv, acc, exp_req, keep;
    int live, lat;
    pend_t e, n;
    rv = pend.size() > 0 && pend[0].due <= cyc;
    rst_n = rn;
    bus.redirect_valid = rd;
    bus.redirect_pc = rpc;
    bus.imem_req_ready = rdy;
    bus.if_ready = ifr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data = rv ? pend[0].data : $urandom();
    #1;
    live = mq.size();
    foreach (pend[i]) if (pend[i].ep == epoch) live++;
    exp_req = rn && !rd && live < DEPTH && pend.size() < DEPTH;
    s_if_valid = bus.if_valid;
    s_if_instr = bus.if_instr;
    s_if_pc4 = bus.if_pc4;
    s_req_valid = bus.imem_req_valid;
    s_req_addr = bus.imem_req_addr;
    s_out = 32'(bus.outstanding);
    if (chk_en) begin
      chk("if_valid", 32'(s_if_valid), 32'(mq.size() != 0));
      chk("if_instr", s_if_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
      chk("if_pc4", s_if_pc4, mq.size() != 0 ? mq[0].pc4 : 32'h0);
      chk("outstanding", s_out, 32'(pend.size()));
      chk("req_valid", 32'(s_req_valid), 32'(exp_req));
      chk("req_addr", s_req_addr, fpc);
    end
    acc = exp_req && rdy;
    if (!rn) begin
      mq.delete();
      pend.delete();
      fpc = RESET_PC;
      epoch++;
      last_due = cyc;
    end else begin
      keep = 0;
      if (rv) begin
        e = pend.pop_front();
        keep = !rd && e.ep == epoch;
      end
      if (rd) begin
        mq.delete();
        fpc = {rpc[31:2], 2'b00};
        epoch++;
      end else begin
        if (mq.size() > 0 && ifr) void'(mq.pop_front());
        if (keep) mq.push_back('{e.data, e.addr + 32'd4});
        if (acc) begin
          lat = $urandom_range(lat_hi, lat_lo);
          n.addr = fpc;
          n.data = word_of(fpc);
          n.ep = epoch;
          n.due = cyc + lat > last_due ? cyc + lat : last_due + 1;
          last_due = n.due;
          pend.push_back(n);
          fpc = fpc + 32'd4;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && pend.size() > 0; i++) step(1, 0, 0, 0, 1);
    chk("drain", 32'(pend.size()), 0);
  endtask
  task automatic wait_valid(input string n, input logic [31:0] pc4);
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(1, 0, 0, 1, 1);
      if (s_if_valid) begin
        chk(n, s_if_pc4, pc4);
        chk({n, "_instr"}, s_if_instr, word_of(pc4 - 32'd4));
        got = 1;
      end
    end
    chk({n, "_timeout"}, 32'(got), 1);
  endtask
  initial begin
    logic [31:0] seen_addr[$], seen_pc4[$];
    int n_acc;
    bit fired;
    rst_n = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data = 0;
    bus.if_ready = 0;
    fpc = RESET_PC;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0);
    chk_en = 1;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("rst_if_valid", 32'(s_if_valid), 0);
    chk("rst_req_valid", 32'(s_req_valid), 0);
    chk("rst_out", s_out, 0);
    chk("rst_instr", s_if_instr, 0);
    chk("rst_pc4", s_if_pc4, 0);
    // cold start, latency 1
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1, 1);
      if (i < 2) chk("cold_idle", 32'(s_if_valid), 0);
      if (s_req_valid) seen_addr.push_back(s_req_addr);
      if (s_if_valid) seen_pc4.push_back(s_if_pc4);
    end
    chk("cold_nreq", 32'(seen_addr.size() >= 3), 1);
    chk("cold_npc4", 32'(seen_pc4.size() >= 3), 1);
    if (seen_addr.size() >= 3 && seen_pc4.size() >= 3) begin
      chk("cold_addr0", seen_addr[0], 32'h0);
      chk("cold_addr1", seen_addr[1], 32'h4);
      chk("cold_addr2", seen_addr[2], 32'h8);
      chk("cold_pc4_0", seen_pc4[0], 32'h4);
      chk("cold_pc4_1", seen_pc4[1], 32'h8);
      chk("cold_pc4_2", seen_pc4[2], 32'hC);
    end
    // stall backpressure
    drain();
    step(1, 1, 32'h100, 1, 1);
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1, 0);
      if (s_req_valid) n_acc++;
    end
    chk("stall_accepts", 32'(n_acc), 4);
    chk("stall_req_low", 32'(s_req_valid), 0);
    seen_pc4.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 1);
      if (s_if_valid) seen_pc4.push_back(s_if_pc4);
    end
    chk("stall_drained", 32'(seen_pc4.size()), 4);
    for (int i = 0; i < 4 && i < seen_pc4.size(); i++)
      chk("stall_order", seen_pc4[i], 32'h104 + 32'(4 * i));
    // redirect with three requests in flight, latency 3
    lat_lo = 3;
    lat_hi = 3;
    drain();
    step(1, 1, 32'h200, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1);
    step(1, 1, 32'h40, 1, 1);
    chk("inflight_out", s_out, 3);
    step(1, 0, 0, 1, 1);
    chk("flush_empty", 32'(s_if_valid), 0);
    wait_valid("redir_pc4", 32'h44);
    // redirect coinciding with a response and a pop, latency 2
    lat_lo = 2;
    lat_hi = 2;
    drain();
    step(1, 1, 32'h300, 1, 1);
    fired = 0;
    for (int i = 0; i < 20 && !fired; i++) begin
      if (mq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
        step(1, 1, 32'h40, 1, 1);
        chk("same_valid", 32'(s_if_valid), 1);
        fired = 1;
      end else step(1, 0, 0, 1, 1);
    end
    chk("same_fired", 32'(fired), 1);
    step(1, 0, 0, 1, 1);
    chk("same_empty", 32'(s_if_valid), 0);
    chk("same_out", s_out, 1);
    wait_valid("same_pc4", 32'h44);
    // address wrap and alignment
    lat_lo = 1;
    lat_hi = 1;
    drain();
    step(1, 1, 32'hFFFF_FFFE, 1, 1);
    step(1, 0, 0, 1, 1);
    chk("wrap_req_v", 32'(s_req_valid), 1);
    chk("wrap_addr0", s_req_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 1, 1);
    chk("wrap_addr1", s_req_addr, 32'h0);
    wait_valid("wrap_pc4_0", 32'h0);
    step(1, 0, 0, 1, 1);
    chk("wrap_pc4_1", s_if_pc4, 32'h4);
    // random traffic, variable latency
    lat_lo = 1;
    lat_hi = 5;
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(999) != 0, $urandom_range(99) < 3, $urandom(),
           $urandom_range(3) != 0, $urandom_range(9) < 7);
      chk("out_bound", 32'(s_out <= DEPTH), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch-side block sitting directly upstream of the IF/ID pipeline registers.
- Generates sequential instruction fetch addresses to a latency-tolerant instruction memory port and buffers returned words in an in-order queue.
- Presents {instruction, PC+4} pairs to IF/ID under a valid/ready handshake.
- Accepts PC redirects from jump, bne and jr resolution, flushes queued and in-flight words, and restarts fetch at the target.

Parameters:
- DEPTH, 4, number of queue entries; also the maximum number of outstanding memory requests; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- redirect_valid  input  1  a PC redirect (jump/bne/jr taken) this cycle.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 00.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch word address, always 4-byte aligned.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response word valid; responses return in request order.
- imem_rsp_data  input  32  instruction word.
- if_valid  output  1  queue head valid toward IF/ID.
- if_instr  output  32  head instruction; 32'h0 (nop) when if_valid=0.
- if_pc4  output  32  head instruction address + 4; 32'h0 when if_valid=0.
- if_ready  input  1  IF/ID write enable; low during load-use stall.
- outstanding  output  log2(DEPTH)+1  in-flight request count, for debug and verification.

Behaviour:
- State:
  - fetch_pc (32)
  - queue of DEPTH entries {instr, pc4}, with rd_ptr, wr_ptr, count
  - out_cnt: requests accepted with no response yet
  - drop_cnt: responses still to discard after a redirect
- Reset (reset=0 at a clock edge):
  - fetch_pc=RESET_PC; count=out_cnt=drop_cnt=0; pointers=0.
  - All outputs 0 in the following cycle.
  - Reset mid-operation discards all queued and in-flight state. Responses arriving after reset are dropped only if the memory is also reset, and the memory is reset together with this block.
- Request issue:
  - imem_req_valid = !redirect_valid && (count + out_cnt - drop_cnt < DEPTH). This reserves a queue slot for every live in-flight request.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0) and out_cnt += 1.
  - imem_req_valid may drop without ready only in a redirect cycle. The memory port is a single-cycle-accept port and tolerates this.
- Response handling (imem_rsp_valid=1):
  - out_cnt -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise push {imem_rsp_data, addr+4}. addr+4 is tracked by a 32-bit rsp_pc register that advances by 4 per kept response; pc4 = rsp_pc + 4.
  - A response can never find the queue full, because slots are reserved at issue. A violation is flagged by a simulation-only assertion.
- Output:
  - if_valid = (count != 0); head entry drives if_instr and if_pc4.
  - Pop on if_valid && if_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Single-cycle latency from response to if_valid: a word returned in cycle N is visible in cycle N+1. There is no bypass.
- Redirect (redirect_valid=1 at an edge) has priority over all other updates:
  - count=0, pointers reset.
  - fetch_pc = {redirect_pc[31:2],2'b00}; rsp_pc = the same value.
  - drop_cnt = out_cnt minus (1 if a response arrives this cycle), so the same-cycle response is discarded too.
  - No request is accepted in the redirect cycle.
  - First new request is issued in the next cycle; earliest new if_valid is request accept + memory latency + 1.
  - A pop in the same cycle as a redirect is ignored; the head is flushed.
  - Back-to-back redirects: the later one wins. drop_cnt is recomputed from out_cnt each time.
- Counters saturate in no case; their widths cover 0..DEPTH exactly.

Decomposition:
- Shared package (pipeline_pkg):
  - INSTR_W=32, NOP_INSTR=32'h0, PC_STEP=4.
  - Typedef fetch_entry_t {instr[31:0], pc4[31:0]}.
- One sub-module: sync_fifo_2w (generic synchronous FIFO; parameters WIDTH, DEPTH; push/pop/flush; count output), instantiated with WIDTH=64.
- Issue and drop logic stays in the top module.

Test Plan:
- Reset and cold start: RESET_PC=0, memory latency 1, if_ready=1 -> requests at 0,4,8,… on consecutive cycles. The first if_valid cycle shows if_pc4=4, then 8, 12. After reset deassertion the outputs are 0 until the first word arrives.
- Stall backpressure: hold if_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 requests accepted, imem_req_valid=0 while count+out_cnt=4. On release, words drain in order with no loss or duplicates.
- Redirect with in-flight requests: latency 3, three requests outstanding, redirect_pc=32'h0000_0040 -> the 3 stale responses are discarded and the next if_valid shows if_pc4=32'h44. The queue is empty in the cycle after redirect.
- Same-cycle redirect + response + pop: fire all three together -> the response is dropped and the pop has no effect. Then drop_cnt=out_cnt-1 and the first kept word is from 32'h40.
- Address wrap and alignment: redirect_pc=32'hFFFF_FFFE -> fetch addresses FFFF_FFFC then 0000_0000; if_pc4 shows 0000_0000 then 0000_0004.
- Variable-latency memory: random imem_req_ready and response latency 1..5 over 10k cycles, random redirects and stalls -> the delivered stream matches a reference PC-sequence model and out_cnt never exceeds DEPTH.
